// File: rtl/int_ctrl.sv
// int_ctrl: six-source interrupt controller with synchronizers, edge/level
// pending logic, a mask register, an edge-event counter and an external ack.
//
// Ports
//   clk      - single clock, all state changes on its rising edge
//   reset    - asynchronous, active-low reset
//   irq_src  - raw asynchronous interrupt sources (bit0 TC0, bit1 TC1, bit2 ext)
//   addr     - register word select (0 PEND, 1 MASK, 2 STATUS, 3 COUNT)
//   we       - register write strobe
//   din      - register write data (only bits 5:0 are used)
//   dout     - register read data, combinational from addr
//   hwint    - registered PEND & MASK to the CPU
//   int_ack  - one-cycle acknowledge to the external interrupt generator
module int_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,           // legal range 2..4
    parameter logic [5:0]  EDGE_MASK   = 6'b000100    // 1 = edge-latched, 0 = level
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  irq_src,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic [5:0]  hwint,
    output logic        int_ack
);

    localparam int unsigned NSRC    = 6;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned EXT_BIT = 2;

    localparam logic [1:0] ADDR_PEND   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    localparam logic [NSRC-1:0] MASK_RESET = 6'h3F;

    logic [NSRC-1:0]  sync_q [SYNC_STAGES];
    logic [NSRC-1:0]  sync;
    logic [NSRC-1:0]  prev;
    logic [NSRC-1:0]  pend;
    logic [NSRC-1:0]  mask;
    logic [CNT_W-1:0] count;

    logic             wr_pend;
    logic             wr_mask;
    logic             wr_count;
    logic [NSRC-1:0]  w1c;
    logic [NSRC-1:0]  rise;
    logic [NSRC-1:0]  pend_nxt;
    logic             edge_set;
    logic             ack_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [NSRC-1:0]  mask_nxt;

    // din[31:6] carry no meaning on any register
    logic unused_din;
    assign unused_din = ^din[DATA_W-1:NSRC];

    // Per-bit synchronizer chain; the last stage is the usable sync value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= irq_src;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Decode of write strobes and next-state values
    always_comb begin
        wr_pend  = we && (addr == ADDR_PEND);
        wr_mask  = we && (addr == ADDR_MASK);
        wr_count = we && (addr == ADDR_COUNT);

        // W1C only reaches edge bits; level bits ignore it
        w1c  = wr_pend ? (din[NSRC-1:0] & EDGE_MASK) : '0;
        rise = sync & ~prev & EDGE_MASK;

        // Edge bits: set beats clear. Level bits follow prev, i.e. they load
        // the same sync value prev loads on this edge.
        pend_nxt = (((pend & ~w1c) | rise) & EDGE_MASK) | (sync & ~EDGE_MASK);

        // Any edge bit going 0->1 counts once per cycle
        edge_set = |(rise & ~pend);

        count_nxt = count;
        if (wr_count) begin
            count_nxt = '0;
        end else if (edge_set) begin
            count_nxt = count + CNT_W'(1);
        end

        mask_nxt = wr_mask ? din[NSRC-1:0] : mask;

        // Ack only when a real clear of a set ext bit happens with no new edge
        ack_nxt = w1c[EXT_BIT] & pend[EXT_BIT] & ~rise[EXT_BIT];
    end

    // Controller state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev    <= '0;
            pend    <= '0;
            mask    <= MASK_RESET;
            count   <= '0;
            hwint   <= '0;
            int_ack <= 1'b0;
        end else begin
            prev    <= sync;
            pend    <= pend_nxt;
            mask    <= mask_nxt;
            count   <= count_nxt;
            hwint   <= pend & mask;
            int_ack <= ack_nxt;
        end
    end

    // Register read mux
    always_comb begin
        dout = '0;
        case (addr)
            ADDR_PEND:   dout = DATA_W'(pend);
            ADDR_MASK:   dout = DATA_W'(mask);
            ADDR_STATUS: dout = DATA_W'(pend & mask);
            ADDR_COUNT:  dout = DATA_W'(count);
            default:     dout = '0;
        endcase
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth per interrupt source (legal 2..4).
REQ-002 SHALL have parameter EDGE_MASK, default 6'b000100, meaning a 1 bit selects an edge-triggered latched source and a 0 bit selects a level source.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-005 SHALL have port irq_src, input, 6 bits: raw asynchronous sources (bit0 TC0 IRQ, bit1 TC1 IRQ, bit2 external interrupt, bits 5:3 reserved).
REQ-006 SHALL have port addr, input, 2 bits: register word select (0 PEND, 1 MASK, 2 STATUS, 3 COUNT).
REQ-007 SHALL have port we, input, 1 bit: register write strobe, sampled on the clk rising edge.
REQ-008 SHALL have port din, input, 32 bits: register write data.
REQ-009 SHALL have port dout, output, 32 bits: register read data, combinational from addr.
REQ-010 SHALL have port hwint, output, 6 bits: registered masked-pending vector driven to the CPU HWInt input.
REQ-011 SHALL have port int_ack, output, 1 bit: one-cycle acknowledge pulse to the external interrupt generator.

Function
REQ-012 Each irq_src bit SHALL pass through a chain of SYNC_STAGES flops; the last stage is called sync.
REQ-013 A per-bit register prev SHALL capture sync every cycle.
REQ-014 An edge source SHALL set its PEND bit on the clock edge where sync=1 and prev=0.
REQ-015 A level source SHALL load its PEND bit with prev every cycle; W1C writes to level bits have no effect.
REQ-016 A write with addr=0 SHALL clear each edge-source PEND bit whose din bit is 1 (W1C).
REQ-017 When set and W1C of the same edge bit coincide in one cycle, set SHALL win and the bit stays 1.
REQ-018 A write with addr=1 SHALL load MASK from din[5:0].
REQ-019 Writes with addr=2 SHALL be ignored.
REQ-020 hwint SHALL register (PEND & MASK) every cycle, so hwint lags PEND/MASK changes by exactly one cycle.
REQ-021 End-to-end latency: a raw rise set up before edge k SHALL make hwint 1 after edge k+SYNC_STAGES+1, for both edge and level sources.
REQ-022 COUNT SHALL be 8 bits and SHALL increment by 1 in each cycle where at least one edge-source PEND bit goes 0->1; multiple simultaneous sets count once.
REQ-023 COUNT SHALL wrap from 255 to 0.
REQ-024 A write with addr=3 SHALL clear COUNT to 0 regardless of din; if an increment coincides with that write, the write wins and COUNT=0.
REQ-025 int_ack SHALL pulse 1 for exactly the one cycle following an addr=0 write that clears PEND[2] while PEND[2] was 1 and no same-cycle set occurred; otherwise it is 0.
REQ-026 dout SHALL read as follows, with all unlisted bits reading 0:
- addr 0: {26'b0, PEND}
- addr 1: {26'b0, MASK}
- addr 2: {26'b0, PEND & MASK}
- addr 3: {24'b0, COUNT}
REQ-027 din bits 31:6 SHALL be ignored on all writes.

Reset
REQ-028 While reset=0, SHALL asynchronously force:
- synchronizer stages, prev, PEND, COUNT, hwint, int_ack = 0
- MASK = 6'h3F
REQ-029 Assertion of reset mid-operation SHALL discard pending bits and in-flight synchronizer data; no hwint or int_ack pulse SHALL follow the release of reset.
REQ-030 After reset release, a source already high SHALL be treated as a rising edge and latched after SYNC_STAGES+1 edges.

Verification
REQ-031 Reset check: hold reset=0, irq_src=6'h3F -> hwint=0, int_ack=0, dout(addr1)=0x3F, dout(addr3)=0.
REQ-032 Edge latency: SYNC_STAGES=2; irq_src[2] 0->1 before edge 0, held high -> hwint[2]=1 after edge 3, PEND=0x04, COUNT=1; write addr0 din=0x04 -> PEND=0, hwint[2]=0 one cycle later, int_ack high for exactly one cycle.
REQ-033 Level source: irq_src[0]=1 for 5 cycles then 0; write addr0 din=0x01 mid-pulse -> PEND[0] unaffected, hwint[0] high for 5 cycles offset by 3 edges, COUNT unchanged.
REQ-034 Mask: MASK=0x3B, fire bit2 -> PEND=0x04, STATUS=0, hwint=0; write MASK=0x3F -> hwint[2]=1 one cycle later.
REQ-035 Collision: a W1C of bit2 in the same cycle as a fresh bit2 edge -> PEND[2]=1, int_ack stays 0; 256 edge events -> COUNT=0; a clear write coinciding with an increment -> COUNT=0.
REQ-036 Reset mid-flight: raw rise on bit2 one edge before reset=0, held high through reset -> all state zero; after release, hwint[2]=1 only after SYNC_STAGES+1 edges, int_ack=0 throughout.
